// File: rtl/mul_div_pkg.sv
// mul_div_pkg: widths and divider state type shared by mul_unit and div_unit
package mul_div_pkg;
    localparam int A_W = 16;
    localparam int B_W = 8;
    localparam int CNT_W = $clog2(A_W);
    typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: start/done handshake, operands and results of div_unit
interface div_unit_if;
    import mul_div_pkg::*;
    logic start;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic busy;
    logic done;
    logic [A_W-1:0] Q;
    logic [B_W-1:0] R;
    logic div_zero;
    modport master (output start, A, B, input busy, done, Q, R, div_zero);
    modport slave (input start, A, B, output busy, done, Q, R, div_zero);
endinterface

// File: rtl/div_sub_stage.sv
// div_sub_stage: ripple compare-and-subtract of {1'b0,b} from the (B_W+1)-bit trial value t
module div_sub_stage
    import mul_div_pkg::*;
(
    input  logic [B_W:0]   t,
    input  logic [B_W-1:0] b,
    output logic [B_W-1:0] p_next,
    output logic           qbit
);
    logic [B_W:0] bw;
    logic [B_W-1:0] d;
    assign bw[0] = 1'b0;
    for (genvar i = 0; i < B_W; i++) begin : g_rs
        assign d[i] = t[i] ^ b[i] ^ bw[i];
        assign bw[i+1] = (~t[i] & b[i]) | (~(t[i] ^ b[i]) & bw[i]);
    end
    // top bit subtracts a zero divisor bit, so no borrow out means t >= b
    assign qbit = t[B_W] | ~bw[B_W];
    assign p_next = qbit ? d : t[B_W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: sequential radix-2 restoring divider, one quotient bit per cycle
module div_unit
    import mul_div_pkg::*;
(
    input logic clk,
    input logic rst,
    div_unit_if.slave d
);
    div_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [A_W-1:0] dvd, q;
    logic [B_W-1:0] dvs, p, r, p_next;
    logic qbit, dz;
    div_sub_stage u_sub (.t({p, dvd[A_W-1]}), .b(dvs), .p_next(p_next), .qbit(qbit));
    // results are loaded on the edge entering FIN so they are valid while done is high
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            dvd <= '0;
            dvs <= '0;
            p <= '0;
            q <= '0;
            r <= '0;
            dz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (d.start) begin
                    dvd <= d.A;
                    dvs <= d.B;
                    p <= '0;
                    cnt <= CNT_W'(A_W - 1);
                    if (d.B == '0) begin
                        state <= FIN;
                        q <= '1;
                        r <= '1;
                        dz <= 1'b1;
                    end else state <= CALC;
                end
                CALC: begin
                    dvd <= {dvd[A_W-2:0], qbit};
                    p <= p_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIN;
                        q <= {dvd[A_W-2:0], qbit};
                        r <= p_next;
                        dz <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    assign d.busy = state == CALC;
    assign d.done = state == FIN;
    assign d.Q = q;
    assign d.R = r;
    assign d.div_zero = dz;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table vectors, corner sequences and mul round trip checked through a scoreboard
module tb_div_unit;
    import mul_div_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    div_unit_if d ();
    div_unit dut (.clk(clk), .rst(rst), .d(d));
    typedef struct {logic [15:0] a; logic [7:0] b; logic [15:0] q; logic [7:0] r; logic dz;} vec_t;
    typedef struct {logic [15:0] q; logic [7:0] r; logic dz;} exp_t;
    exp_t sb[$];
    vec_t vt[7];
    int checks = 0;
    int errors = 0;
    logic [15:0] last_q = '0;
    logic [7:0] last_r = '0;
    logic last_dz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                      input logic [7:0] er, input logic edz, input int pulse);
        exp_t e;
        int seen = 0;
        int nbusy = 0;
        int moved = 0;
        e = '{eq, er, edz};
        sb.push_back(e);
        @(negedge clk);
        d.start = 1'b1; d.A = a; d.B = b;
        @(posedge clk);
        #1 d.start = 1'b0; d.A = 16'($urandom); d.B = 8'($urandom);
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(negedge clk);
            if (d.done) seen = c;
            else begin
                nbusy += int'(d.busy);
                if (d.Q !== last_q || d.R !== last_r || d.div_zero !== last_dz) moved++;
            end
            d.start = (c == pulse);
        end
        d.start = 1'b0;
        e = sb.pop_front();
        chk("latency", seen, edz ? 1 : 17);
        chk("busy_cycles", nbusy, edz ? 0 : 16);
        chk("hold", moved, 0);
        if (seen != 0) begin
            chk("busy_at_done", d.busy, 0);
            chk("q", d.Q, e.q);
            chk("r", d.R, e.r);
            chk("div_zero", d.div_zero, e.dz);
            if (!d.div_zero) begin
                chk("invariant", 32'(d.Q) * b + d.R, a);
                chk("r_lt_b", d.R < b, 1);
            end
        end
        last_q = eq; last_r = er; last_dz = edz;
    endtask

    initial begin
        int dn;
        logic [7:0] x, y;
        vt[0] = '{16'd1000, 8'd7, 16'd142, 8'd6, 1'b0};
        vt[1] = '{16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0};
        vt[2] = '{16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0};
        vt[3] = '{16'd5, 8'd200, 16'd0, 8'd5, 1'b0};
        vt[4] = '{16'd0, 8'd9, 16'd0, 8'd0, 1'b0};
        vt[5] = '{16'd1234, 8'd0, 16'hFFFF, 8'hFF, 1'b1};
        vt[6] = '{16'd100, 8'd10, 16'd10, 8'd0, 1'b0};
        d.start = 1'b0; d.A = '0; d.B = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", d.busy, 0);
        chk("rst_done", d.done, 0);
        chk("rst_q", d.Q, 0);
        chk("rst_r", d.R, 0);
        chk("rst_dz", d.div_zero, 0);
        rst = 1'b1;
        foreach (vt[i]) op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, 0);
        op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 3);
        @(negedge clk);
        d.start = 1'b1; d.A = 16'd1000; d.B = 8'd7;
        @(posedge clk);
        #1 d.start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", d.busy, 0);
        chk("abort_done", d.done, 0);
        chk("abort_q", d.Q, 0);
        chk("abort_r", d.R, 0);
        chk("abort_dz", d.div_zero, 0);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(d.done);
        end
        chk("abort_no_done", dn, 0);
        last_q = '0; last_r = '0; last_dz = 1'b0;
        op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 0);
        for (int k = 0; k < 1000; k++) begin
            x = 8'($urandom_range(1, 255));
            y = 8'($urandom_range(1, 255));
            op(16'(x * y), y, 16'(x), 8'd0, 1'b0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
